cphy_mapper_tx: RTL and testbench

- Transmit-side counterpart of the C-PHY receive demapper.
- Accepts 16-bit high-speed words over a valid/ready handshake and maps each word to seven 3-bit symbol codes (flip, rotation, polarity).
- Streams the seven symbols one per cycle to the downstream symbol encoder, with backpressure.
- Sits between the TX lane data path and the wire-state encoder.

---
 rtl/cphy_pkg.sv | 64 ++++++
 rtl/cphy_sym_serializer.sv | 74 +++++++
 rtl/cphy_mapper_tx.sv | 79 +++++++
 tb/tb_cphy_mapper_tx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cphy_pkg.sv
// Shared C-PHY symbol types and constants, plus the 16-bit word to 7-symbol map function
// that is the exact inverse of the receive demapper.
package cphy_pkg;

  localparam int unsigned SYMS_PER_WORD = 7;

  typedef struct packed {
    logic [6:0] flip;
    logic [6:0] rot;
    logic [6:0] pol;
  } sym_fields_t;

  // D[15:12] picks the flip pattern: 0..3 no flip, 4..10 one flip at D[15:12]-4,
  // 11..15 together with D[11:10] index a flip pair in lexicographic order.
  localparam logic [3:0]  SelOneFlip   = 4'd4;
  localparam logic [3:0]  SelTwoFlip   = 4'd11;
  localparam int unsigned NumFlipPairs = 20;

  // Pair {5,6} (7'h60) is the one pattern left unused; the demapper flags it invalid.
  localparam logic [NumFlipPairs-1:0][6:0] FlipPairMask = {
    7'h50, 7'h30, 7'h48, 7'h28, 7'h18, 7'h44, 7'h24, 7'h14, 7'h0C, 7'h42,
    7'h22, 7'h12, 7'h0A, 7'h06, 7'h41, 7'h21, 7'h11, 7'h09, 7'h05, 7'h03
  };

  function automatic sym_fields_t cphy_map16(input logic [15:0] data);
    sym_fields_t sym;
    logic [6:0]  mask;
    logic [4:0]  pair_idx;
    logic [3:0]  sel;
    logic [3:0]  bit_pos;
    logic        two_flip;
    logic        lead_flip;
    sym       = '0;
    sel       = data[15:12];
    pair_idx  = '0;
    bit_pos   = '0;
    two_flip  = 1'b0;
    lead_flip = 1'b1;
    if (sel < SelOneFlip) begin
      mask = '0;
    end else if (sel < SelTwoFlip) begin
      mask = 7'b1 << (sel - SelOneFlip);
    end else begin
      pair_idx = {3'(sel - SelTwoFlip), data[11:10]};
      mask     = FlipPairMask[pair_idx];
      two_flip = 1'b1;
    end
    for (int i = 0; i < SYMS_PER_WORD; i++) begin
      if (mask[i]) begin
        sym.flip[i] = 1'b1;
        // rot/pol at flip positions never reach the wire: lead of a pair 10, otherwise 01.
        if (two_flip && lead_flip) sym.rot[i] = 1'b1;
        else                       sym.pol[i] = 1'b1;
        lead_flip = 1'b0;
      end else begin
        sym.rot[i] = data[bit_pos + 4'd1];
        sym.pol[i] = data[bit_pos];
        bit_pos    = bit_pos + 4'd2;
      end
    end
    return sym;
  endfunction

endpackage

// File: rtl/cphy_sym_serializer.sv
// Stage B of the TX mapper: holds one mapped word and shifts its seven symbols out one per
// accepted cycle toward the configured output bit.
module cphy_sym_serializer
  import cphy_pkg::*;
#(
  parameter bit MsbFirst = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  sym_fields_t fields_i,
  input  logic        sym_ready_i,
  output logic        valid_o,
  output logic        last_o,
  output logic [2:0]  cnt_o,
  output logic        flip_o,
  output logic        rot_o,
  output logic        pol_o
);

  localparam logic [2:0] LastCnt = 3'(SYMS_PER_WORD - 1);

  sym_fields_t sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        v_q, v_d;
  logic        accept;

  function automatic logic [6:0] shift1(input logic [6:0] f);
    return MsbFirst ? {f[5:0], 1'b0} : {1'b0, f[6:1]};
  endfunction

  assign accept = v_q && sym_ready_i;
  assign last_o = accept && (cnt_q == LastCnt);

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    v_d   = v_q;
    if (load_i) begin
      sh_d  = fields_i;
      cnt_d = '0;
      v_d   = 1'b1;
    end else if (last_o) begin
      // Return to the idle image so an empty stage looks like reset.
      sh_d  = '0;
      cnt_d = '0;
      v_d   = 1'b0;
    end else if (accept) begin
      sh_d.flip = shift1(sh_q.flip);
      sh_d.rot  = shift1(sh_q.rot);
      sh_d.pol  = shift1(sh_q.pol);
      cnt_d     = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      cnt_q <= '0;
      v_q   <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      v_q   <= v_d;
    end
  end

  assign valid_o = v_q;
  assign cnt_o   = cnt_q;
  assign flip_o  = MsbFirst ? sh_q.flip[6] : sh_q.flip[0];
  assign rot_o   = MsbFirst ? sh_q.rot[6]  : sh_q.rot[0];
  assign pol_o   = MsbFirst ? sh_q.pol[6]  : sh_q.pol[0];

endmodule

// File: rtl/cphy_mapper_tx.sv
// C-PHY TX mapper: accepts 16-bit words, maps each to seven {flip, rot, pol} symbols and
// streams them one per cycle to the wire-state encoder with backpressure.
module cphy_mapper_tx
  import cphy_pkg::sym_fields_t;
  import cphy_pkg::cphy_map16;
#(
  parameter bit          MSB_FIRST     = 1'b0,
  parameter int unsigned SYMS_PER_WORD = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] TxDataHS,
  input  logic        TxValidHS,
  output logic        TxReadyHS,
  output logic        TxSymValid,
  input  logic        TxSymReady,
  output logic        TxFlip,
  output logic        TxRotation,
  output logic        TxPolarity,
  output logic [2:0]  TxSymIndex,
  output logic        TxWordStart,
  output logic        TxBusy
);

  localparam logic [2:0] LastIdx = 3'(SYMS_PER_WORD - 1);

  sym_fields_t a_q, a_d;
  logic        a_v_q, a_v_d;
  logic        b_v, b_last, b_load, in_accept;
  logic [2:0]  cnt;

  // A drains into B whenever B is empty or finishing its last symbol this cycle.
  assign b_load    = a_v_q && (!b_v || b_last);
  assign TxReadyHS = !a_v_q || b_load;
  assign in_accept = TxValidHS && TxReadyHS;

  always_comb begin
    a_d   = a_q;
    a_v_d = a_v_q;
    if (in_accept) begin
      a_d   = cphy_map16(TxDataHS);
      a_v_d = 1'b1;
    end else if (b_load) begin
      a_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      a_v_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      a_v_q <= a_v_d;
    end
  end

  cphy_sym_serializer #(
    .MsbFirst(MSB_FIRST)
  ) u_ser (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (b_load),
    .fields_i   (a_q),
    .sym_ready_i(TxSymReady),
    .valid_o    (b_v),
    .last_o     (b_last),
    .cnt_o      (cnt),
    .flip_o     (TxFlip),
    .rot_o      (TxRotation),
    .pol_o      (TxPolarity)
  );

  assign TxSymValid  = b_v;
  assign TxSymIndex  = MSB_FIRST ? (LastIdx - cnt) : cnt;
  assign TxWordStart = b_v && (cnt == 3'd0);
  assign TxBusy      = a_v_q || b_v;

endmodule

// File: tb/tb_cphy_mapper_tx.sv
// Bench for cphy_mapper_tx: LSB-first and MSB-first instances share one stimulus stream;
// symbols are scoreboarded against a table built from the mapping rules and demapped back.
module tb_cphy_mapper_tx;

  typedef struct packed {
    logic       f;
    logic       r;
    logic       p;
    logic [2:0] idx;
    logic       ws;
  } sym_t;

  logic        clk, rst_n;
  logic [15:0] TxDataHS;
  logic        TxValidHS, TxSymReady;
  logic        rdy_l, sv_l, f_l, r_l, p_l, ws_l, busy_l;
  logic        rdy_m, sv_m, f_m, r_m, p_m, ws_m, busy_m;
  logic [2:0]  idx_l, idx_m;

  cphy_mapper_tx #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .TxDataHS(TxDataHS), .TxValidHS(TxValidHS), .TxReadyHS(rdy_l),
    .TxSymValid(sv_l), .TxSymReady(TxSymReady), .TxFlip(f_l), .TxRotation(r_l),
    .TxPolarity(p_l), .TxSymIndex(idx_l), .TxWordStart(ws_l), .TxBusy(busy_l)
  );

  cphy_mapper_tx #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .TxDataHS(TxDataHS), .TxValidHS(TxValidHS), .TxReadyHS(rdy_m),
    .TxSymValid(sv_m), .TxSymReady(TxSymReady), .TxFlip(f_m), .TxRotation(r_m),
    .TxPolarity(p_m), .TxSymIndex(idx_m), .TxWordStart(ws_m), .TxBusy(busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sym_cnt, first_sym, last_sym;
  bit rand_valid, rand_ready, stall;
  logic [20:0] tbl [65536];
  logic [15:0] src_q[$], sent_q[$];
  logic [20:0] rx_q[$];
  sym_t        exp_l[$], exp_m[$];
  int          acc_cyc[$];
  logic [6:0]  rx_f, rx_r, rx_p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Demapper model: returns {invalid, data} from the symbols actually seen on the wire.
  function automatic logic [16:0] demap(input logic [6:0] f, input logic [6:0] r,
                                        input logic [6:0] p);
    logic [15:0] d;
    int k, n, found, lex;
    int fp[2];
    d = '0; k = 0; n = 0; found = -1; lex = 0; fp[0] = 0; fp[1] = 0;
    for (int i = 0; i < 7; i++) begin
      if (f[i]) begin
        if (k < 2) fp[k] = i;
        k++;
      end else begin
        d[n+1] = r[i];
        d[n]   = p[i];
        n += 2;
      end
    end
    if (k == 1) d[15:12] = 4'(4 + fp[0]);
    if (k == 2) begin
      for (int a = 0; a < 7; a++)
        for (int b = a + 1; b < 7; b++) begin
          if (a == fp[0] && b == fp[1]) found = lex;
          lex++;
        end
      if (found >= 20) return {1'b1, 16'h0};
      d[15:12] = 4'(11 + found / 4);
      d[11:10] = 2'(found % 4);
    end
    if (k > 2) return {1'b1, 16'h0};
    return {1'b0, d};
  endfunction

  // Enumerate every legal symbol sequence and index it by the word it demaps to.
  task automatic build_table();
    logic [6:0] f, r, p;
    logic [16:0] dm;
    int k, nd, j;
    bit first;
    for (int m = 0; m < 128; m++) begin
      f = 7'(m);
      k = $countones(f);
      if (k <= 2 && f != 7'h60) begin
        nd = 2 * (7 - k);
        for (int v = 0; v < (1 << nd); v++) begin
          r = '0; p = '0; j = 0; first = 1'b1;
          for (int i = 0; i < 7; i++) begin
            if (f[i]) begin
              if (k == 2 && first) r[i] = 1'b1;
              else                 p[i] = 1'b1;
              first = 1'b0;
            end else begin
              r[i] = v[j+1];
              p[i] = v[j];
              j += 2;
            end
          end
          dm = demap(f, r, p);
          tbl[dm[15:0]] = {f, r, p};
        end
      end
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    logic [20:0] c;
    sym_t e;
    c = tbl[d];
    for (int j = 0; j < 7; j++) begin
      e.f = c[14+j]; e.r = c[7+j]; e.p = c[j]; e.idx = 3'(j); e.ws = (j == 0);
      exp_l.push_back(e);
      e.f = c[20-j]; e.r = c[13-j]; e.p = c[6-j]; e.idx = 3'(6 - j); e.ws = (j == 0);
      exp_m.push_back(e);
    end
  endtask

  task automatic drive();
    TxValidHS  = (src_q.size() > 0) && (!rand_valid || $urandom_range(0, 1) == 1);
    TxDataHS   = TxValidHS ? src_q[0] : 16'($urandom);
    TxSymReady = !stall && (!rand_ready || $urandom_range(0, 3) != 0);
  endtask

  task automatic observe();
    sym_t e;
    logic [15:0] d;
    if (TxValidHS && rdy_l) begin
      d = src_q.pop_front();
      sent_q.push_back(d);
      acc_cyc.push_back(cyc);
      push_word(d);
    end
    if (sv_l && TxSymReady) begin
      if (exp_l.size() == 0 || exp_m.size() == 0) begin
        chk("unexpected_sym", 1, 0);
      end else begin
        e = exp_l.pop_front();
        chk("sym_lsb", {sv_l, f_l, r_l, p_l, idx_l, ws_l}, {1'b1, e});
        e = exp_m.pop_front();
        chk("sym_msb", {sv_m, f_m, r_m, p_m, idx_m, ws_m}, {1'b1, e});
      end
      if (sym_cnt == 0) first_sym = cyc;
      last_sym = cyc;
      sym_cnt++;
      rx_f[idx_l] = f_l; rx_r[idx_l] = r_l; rx_p[idx_l] = p_l;
      if (idx_l == 3'd6) rx_q.push_back({rx_f, rx_r, rx_p});
    end
  endtask

  task automatic tick();
    drive();
    #1;
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_l.size() > 0 || busy_l) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_in_budget"}, (n < budget), 1);
  endtask

  task automatic check_roundtrip(input string tag);
    logic [20:0] w;
    logic [15:0] d;
    chk({tag, "_word_count"}, rx_q.size(), sent_q.size());
    while (rx_q.size() > 0 && sent_q.size() > 0) begin
      w = rx_q.pop_front();
      d = sent_q.pop_front();
      chk({tag, "_roundtrip"}, demap(w[20:14], w[13:7], w[6:0]), {1'b0, d});
    end
    rx_q.delete();
    sent_q.delete();
  endtask

  logic [15:0] gd[4];
  logic [20:0] gc[4];
  logic [5:0]  snap;
  cphy_pkg::sym_fields_t sf;
  int bad, n;

  initial begin
    TxValidHS = 0; TxDataHS = '0; TxSymReady = 1; rst_n = 1;
    rand_valid = 0; rand_ready = 0; stall = 0; sym_cnt = 0; first_sym = 0; last_sym = 0;
    rx_f = '0; rx_r = '0; rx_p = '0;
    build_table();
    #1 rst_n = 0;
    #2;
    chk("rst_ready", {rdy_l, rdy_m}, 2'b11);
    chk("rst_symvalid", {sv_l, sv_m}, 2'b00);
    chk("rst_fields", {f_l, r_l, p_l, f_m, r_m, p_m}, 6'b0);
    chk("rst_index_lsb", idx_l, 3'd0);
    chk("rst_index_msb", idx_m, 3'd6);
    chk("rst_wordstart", {ws_l, ws_m}, 2'b00);
    chk("rst_busy", {busy_l, busy_m}, 2'b00);

    // Exhaustive round trip of the combinational map through the demapper model.
    for (int d = 0; d < 65536; d++) begin
      sf = cphy_pkg::cphy_map16(16'(d));
      chk("map_roundtrip", demap(sf.flip, sf.rot, sf.pol), {1'b0, 16'(d)});
    end

    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // Golden words, with 2-edge latency and the MSB-first first symbol of 0xCFD8.
    gd[0] = 16'hCFD8; gc[0] = {7'h0A, 7'h66, 7'h78};
    gd[1] = 16'h000F; gc[1] = {7'h00, 7'h03, 7'h03};
    gd[2] = 16'h912B; gc[2] = {7'h20, 7'h07, 7'h31};
    gd[3] = 16'hD90D; gc[3] = {7'h42, 7'h06, 7'h65};
    for (int i = 0; i < 4; i++) src_q.push_back(gd[i]);
    tick();
    chk("lat_edge1_symvalid", sv_l, 1'b0);
    chk("lat_edge1_busy", busy_l, 1'b1);
    tick();
    chk("lat_edge2_symvalid", sv_l, 1'b1);
    chk("lat_first_lsb", {ws_l, idx_l, f_l, r_l, p_l}, {1'b1, 3'd0, 3'b000});
    chk("lat_first_msb", {ws_m, idx_m, f_m, r_m, p_m}, {1'b1, 3'd6, 3'b011});
    drain("golden", 200);
    chk("golden_count", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("golden_fields", rx_q[i], gc[i]);
    check_roundtrip("golden");

    // Streaming: 20 back-to-back words, both sides always ready.
    acc_cyc.delete(); sym_cnt = 0;
    for (int i = 0; i < 20; i++) src_q.push_back(16'($urandom));
    drain("stream", 400);
    chk("stream_syms", sym_cnt, 140);
    chk("stream_no_gaps", last_sym - first_sym + 1, 140);
    chk("stream_accepts", acc_cyc.size(), 20);
    bad = 0;
    for (int i = 2; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 7) bad++;
    chk("stream_ready_period", bad, 0);
    check_roundtrip("stream");

    // Backpressure: stall 5 cycles at index 3 with A holding the next word.
    src_q.push_back(16'($urandom)); src_q.push_back(16'($urandom));
    n = 0;
    while (!(sv_l && idx_l == 3'd3) && n < 50) begin tick(); n++; end
    chk("bp_reach_idx3", n < 50, 1);
    snap = {f_l, r_l, p_l, f_m, r_m, p_m};
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      drive();
      #1;
      chk("bp_hold_fields", {f_l, r_l, p_l, f_m, r_m, p_m}, snap);
      chk("bp_hold_index", {sv_l, idx_l, idx_m}, {1'b1, 3'd3, 3'd3});
      chk("bp_ready_low", {rdy_l, rdy_m}, 2'b00);
      observe();
      @(posedge clk); #1; cyc++;
    end
    chk("bp_hold_after", {f_l, r_l, p_l, idx_l}, {snap[5:3], 3'd3});
    stall = 0;
    drain("bp", 100);
    check_roundtrip("bp");

    // Random valid/ready handshakes.
    rand_valid = 1; rand_ready = 1;
    for (int i = 0; i < 300; i++) src_q.push_back(16'($urandom));
    drain("random", 8000);
    check_roundtrip("random");
    rand_valid = 0; rand_ready = 0;

    // Reset in the middle of a word.
    src_q.push_back(16'($urandom));
    n = 0;
    while (!(sv_l && idx_l == 3'd4) && n < 50) begin tick(); n++; end
    chk("rst_mid_reach_idx4", n < 50, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_symvalid", {sv_l, sv_m}, 2'b00);
    chk("rst_mid_busy", {busy_l, busy_m}, 2'b00);
    exp_l.delete(); exp_m.delete(); sent_q.delete(); src_q.delete(); rx_q.delete();
    TxValidHS = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    src_q.push_back(16'($urandom));
    drain("after_rst", 100);
    check_roundtrip("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
